step_dir_shaper: RTL
====================

# step_dir_shaper

Conditions the raw step clock from the motion-profile stage into driver-safe STEP/DIR/EN signals for an external stepper driver. It synchronises and edge-detects incoming step requests and buffers bursts in a small pending counter. Each step is then emitted with guaranteed direction setup, minimum high time and minimum low time, and the block tracks absolute microstep position. It sits directly downstream of the angle-to-step profile generator and drives the board pins.

## Interface
- `STEP_HIGH_CYC`, 3: step_o high time in clk_i cycles (≥1)
- `STEP_LOW_CYC`, 3: minimum step_o low time in clk_i cycles (≥1)
- `DIR_SETUP_CYC`, 5: cycles dir_o must be stable before a step_o rising edge after a direction change (≥1)
- `PEND_WIDTH`, 4: pending-step counter width; saturates at 2^PEND_WIDTH−1
- `POS_WIDTH`, 32: position counter width, two's complement
- `clk_i`  in  1  system clock; the only clock
- `reset_n_i`  in  1  reset, asynchronous, active-low
- `enable_i`  in  1  motor enable (synchronous level)
- `step_req_i`  in  1  raw step clock from the profile stage; one step per rising edge; may be asynchronous
- `dir_i`  in  1  requested direction, 1 = positive; may be asynchronous
- `zero_pos_i`  in  1  synchronous pulse: clear position_o and overflow_o
- `step_o`  out  1  driver STEP
- `dir_o`  out  1  driver DIR
- `en_n_o`  out  1  driver enable, active-low
- `position_o`  out  POS_WIDTH  signed microstep position
- `busy_o`  out  1  high while any step is pending or in flight
- `overflow_o`  out  1  sticky: a request arrived while the pending counter was full

## Operation
- Reset values: step_o=0, dir_o=0, en_n_o=1, position_o=0, busy_o=0, overflow_o=0, pending=0, state IDLE, all synchroniser flops 0.
- step_req_i and dir_i each pass through a 2-flop synchroniser. A rising edge is detected from sync2 & ~sync3.
- Pending counter behaviour:
  - Increments on a detected edge when enable_i=1.
  - Decrements on entry to STEP_HIGH.
  - A simultaneous increment and decrement leaves it unchanged.
  - An edge while the counter is full leaves it unchanged and sets overflow_o.
- The FSM has four states:
  - IDLE: when pending>0 and enable_i=1, compare synced dir with dir_o. If equal, go to STEP_HIGH. Otherwise load the new value into dir_o and go to DIR_SETUP.
  - DIR_SETUP: hold for DIR_SETUP_CYC cycles, then go to STEP_HIGH. Abort to IDLE if enable_i=0.
  - STEP_HIGH: step_o=1 for exactly STEP_HIGH_CYC cycles, then go to STEP_LOW. On entry, position_o changes by ±1 according to dir_o.
  - STEP_LOW: step_o=0 for STEP_LOW_CYC cycles. On exit, go directly to STEP_HIGH if pending>0, enable_i=1 and synced dir equals dir_o; otherwise go to IDLE.
- The synced dir is sampled only in IDLE and at STEP_LOW exit. dir_o never changes in STEP_HIGH or STEP_LOW.
- Effect of enable_i=0:
  - pending is cleared and edges are ignored.
  - A pulse in STEP_HIGH or STEP_LOW completes normally, so there are no runt pulses.
  - en_n_o = ~enable_i, registered.
- Position arithmetic: position_o wraps modulo 2^POS_WIDTH. If zero_pos_i coincides with a step entry, zero wins and position_o=0.
- busy_o = (state≠IDLE) | (pending≠0), registered.

## Timing
- Let the first clk_i edge that samples step_req_i=1 be edge 1:
  - sync2 rises on edge 2.
  - pending increments on edge 3.
  - step_o rises and position_o updates on edge 4 (same direction).
- With a direction change, dir_o updates on edge 4 and step_o rises on edge 4+DIR_SETUP_CYC.
- Minimum step period with back-to-back pending steps in the same direction is STEP_HIGH_CYC+STEP_LOW_CYC cycles.
- en_n_o follows enable_i with 1 cycle latency.
- Mid-operation reset forces all outputs to their reset values asynchronously. Release is synchronous to clk_i.

## Test plan
- Single step, dir_i=1, defaults: step_o rises on edge 4 and is high 3 cycles; position_o = +1; busy_o then falls.
- Burst of 5 request edges 2 cycles apart, same direction: 5 step_o pulses, each high 3 and low ≥3 cycles, period 6; position_o = 5; overflow_o = 0.
- Direction reversal (dir_i=0 before the next request): dir_o changes, and step_o rises exactly 5 cycles later; position_o decrements to 4.
- Flood of 20 request edges faster than the step rate with PEND_WIDTH=4: overflow_o set; no step_o pulse shorter than 3 cycles; zero_pos_i clears overflow_o and position_o.
- enable_i dropped during STEP_HIGH with 3 steps pending: the current pulse completes at full width; no further pulses; pending=0; en_n_o=1 one cycle later.
- reset_n_i asserted mid-pulse: step_o=0 and position_o=0 immediately without a clock edge; the first step after release behaves as in the single-step scenario.

Source files
------------

// File: rtl/step_dir_shaper.sv
// STEP/DIR/EN conditioner: synchronises raw step requests, buffers them in a
// pending counter and emits driver-safe pulses with direction setup and position tracking.
module step_dir_shaper #(
    parameter int STEP_HIGH_CYC = 3,
    parameter int STEP_LOW_CYC  = 3,
    parameter int DIR_SETUP_CYC = 5,
    parameter int PEND_WIDTH    = 4,
    parameter int POS_WIDTH     = 32
) (
    input  logic                        clk_i,
    input  logic                        reset_n_i,
    input  logic                        enable_i,
    input  logic                        step_req_i,
    input  logic                        dir_i,
    input  logic                        zero_pos_i,
    output logic                        step_o,
    output logic                        dir_o,
    output logic                        en_n_o,
    output logic signed [POS_WIDTH-1:0] position_o,
    output logic                        busy_o,
    output logic                        overflow_o
);

    localparam int HL_MAX  = (STEP_HIGH_CYC > STEP_LOW_CYC) ? STEP_HIGH_CYC : STEP_LOW_CYC;
    localparam int CNT_MAX = (HL_MAX > DIR_SETUP_CYC) ? HL_MAX : DIR_SETUP_CYC;
    localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

    localparam logic [CNT_W-1:0]      HIGH_LAST  = CNT_W'(STEP_HIGH_CYC - 1);
    localparam logic [CNT_W-1:0]      LOW_LAST   = CNT_W'(STEP_LOW_CYC - 1);
    localparam logic [CNT_W-1:0]      SETUP_LAST = CNT_W'(DIR_SETUP_CYC - 1);
    localparam logic [CNT_W-1:0]      CNT_ONE    = CNT_W'(1);
    localparam logic [PEND_WIDTH-1:0] PEND_MAX   = {PEND_WIDTH{1'b1}};
    localparam logic [POS_WIDTH-1:0]  POS_ONE    = POS_WIDTH'(1);

    typedef enum logic [1:0] {IDLE, DIR_SETUP, STEP_HIGH, STEP_LOW} state_t;

    state_t                       state_q, state_d;
    logic [CNT_W-1:0]             cnt_q, cnt_d;
    logic [PEND_WIDTH-1:0]        pend_q, pend_d;
    logic [2:0]                   req_sync_q;
    logic [1:0]                   dir_sync_q;
    logic                         dir_q, dir_d;
    logic                         step_q, en_n_q, busy_q;
    logic                         ovf_q, ovf_d;
    logic signed [POS_WIDTH-1:0]  pos_q, pos_d;

    logic dir_sync, req_edge, step_entry, pend_inc;

    assign dir_sync   = dir_sync_q[1];
    assign req_edge   = req_sync_q[1] & ~req_sync_q[2];
    assign step_entry = (state_d == STEP_HIGH) && (state_q != STEP_HIGH);
    assign pend_inc   = req_edge & enable_i & (pend_q != PEND_MAX);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        dir_d   = dir_q;
        unique case (state_q)
            IDLE: begin
                if (pend_q != '0 && enable_i) begin
                    cnt_d = '0;
                    if (dir_sync == dir_q) begin
                        state_d = STEP_HIGH;
                    end else begin
                        dir_d   = dir_sync;
                        state_d = DIR_SETUP;
                    end
                end
            end
            DIR_SETUP: begin
                if (!enable_i) begin
                    state_d = IDLE;
                end else if (cnt_q == SETUP_LAST) begin
                    state_d = STEP_HIGH;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            // Once the pulse starts it always runs to completion: no runt pulses.
            STEP_HIGH: begin
                if (cnt_q == HIGH_LAST) begin
                    state_d = STEP_LOW;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            STEP_LOW: begin
                if (cnt_q == LOW_LAST) begin
                    cnt_d   = '0;
                    state_d = (pend_q != '0 && enable_i && dir_sync == dir_q) ? STEP_HIGH : IDLE;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        pend_d = pend_q + {{(PEND_WIDTH-1){1'b0}}, pend_inc}
                        - {{(PEND_WIDTH-1){1'b0}}, step_entry};
        if (!enable_i) pend_d = '0;

        ovf_d = ovf_q | (req_edge & enable_i & (pend_q == PEND_MAX));
        if (zero_pos_i) ovf_d = 1'b0;

        pos_d = pos_q;
        if (step_entry) pos_d = dir_q ? pos_q + POS_ONE : pos_q - POS_ONE;
        if (zero_pos_i) pos_d = '0;
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            pend_q     <= '0;
            req_sync_q <= '0;
            dir_sync_q <= '0;
            dir_q      <= 1'b0;
            step_q     <= 1'b0;
            en_n_q     <= 1'b1;
            busy_q     <= 1'b0;
            ovf_q      <= 1'b0;
            pos_q      <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            pend_q     <= pend_d;
            req_sync_q <= {req_sync_q[1:0], step_req_i};
            dir_sync_q <= {dir_sync_q[0], dir_i};
            dir_q      <= dir_d;
            step_q     <= (state_d == STEP_HIGH);
            en_n_q     <= ~enable_i;
            busy_q     <= (state_d != IDLE) | (pend_d != '0);
            ovf_q      <= ovf_d;
            pos_q      <= pos_d;
        end
    end

    assign step_o     = step_q;
    assign dir_o      = dir_q;
    assign en_n_o     = en_n_q;
    assign position_o = pos_q;
    assign busy_o     = busy_q;
    assign overflow_o = ovf_q;

endmodule
